// File: rtl/gpioemu_pkg.sv
// ============================================================================
// Module      : gpioemu_pkg
// Description : Shared register map, status code and state encodings for the
//               gpioemu host master. GPIOEMU_HOST_CHECK_EN adds popcount.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpioemu_pkg;

    localparam logic [15:0] ADDR_A1     = 16'h037F;
    localparam logic [15:0] ADDR_A2     = 16'h0388;
    localparam logic [15:0] ADDR_RESULT = 16'h0390;
    localparam logic [15:0] ADDR_ONES   = 16'h0398;
    localparam logic [15:0] ADDR_CTRL   = 16'h03A0;

    localparam logic [1:0]  STATUS_DONE = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_A1,
        ST_WR_A2,
        ST_WR_START,
        ST_POLL,
        ST_GAP,
        ST_RD_RES,
        ST_RD_ONES,
        ST_RESP
    } host_state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_STROBE,
        PH_HOLD
    } bus_phase_t;

`ifdef GPIOEMU_HOST_CHECK_EN
    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'b0, v[i]};
        end
        return n;
    endfunction
`endif

endpackage

`default_nettype wire

// File: rtl/gpioemu_bus_xact.sv
// ============================================================================
// Module      : gpioemu_bus_xact
// Description : Fixed three-cycle (setup / strobe / hold) register access on
//               the gpioemu bus; ack is asserted in the hold cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpioemu_bus_xact
    import gpioemu_pkg::*;
(
    input  logic        clk,
    input  logic        n_reset,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic [15:0] saddress,
    output logic        swr,
    output logic        srd,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    bus_phase_t r_phase;
    bus_phase_t w_phase_next;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_phase <= PH_SETUP;
        end else begin
            r_phase <= w_phase_next;
        end
    end

    always_comb begin
        w_phase_next = PH_SETUP;
        if (req) begin
            case (r_phase)
                PH_SETUP:  w_phase_next = PH_STROBE;
                PH_STROBE: w_phase_next = PH_HOLD;
                default:   w_phase_next = PH_SETUP;
            endcase
        end
    end

    // Pins decode straight from the requester's registered state so an
    // asynchronous reset of the requester drops the strobes at once.
    assign saddress  = req ? addr : 16'h0000;
    assign bus_wdata = (req && we) ? wdata : 32'h0000_0000;
    assign swr       = req &&  we && (r_phase == PH_STROBE);
    assign srd       = req && !we && (r_phase == PH_STROBE);
    assign ack       = req && (r_phase == PH_HOLD);
    assign rdata     = bus_rdata;

endmodule

`default_nettype wire

// File: rtl/gpioemu_host_master.sv
// ============================================================================
// Module      : gpioemu_host_master
// Description : Runs the gpioemu multiply register sequence for one command
//               and returns result/ones. GPIOEMU_HOST_CHECK_EN adds rsp_mismatch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpioemu_host_master
    import gpioemu_pkg::*;
#(
    parameter int POLL_GAP   = 4,
    parameter int POLL_LIMIT = 64
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_a1,
    input  logic [23:0] cmd_a2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [23:0] rsp_ones,
    output logic        rsp_err,
    output logic [15:0] saddress,
    output logic        swr,
    output logic        srd,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
`ifdef GPIOEMU_HOST_CHECK_EN
    output logic        rsp_mismatch,
`endif
    output logic        busy
);

    localparam int c_GAP_W = $clog2(POLL_GAP + 2);
    localparam int c_CNT_W = $clog2(POLL_LIMIT + 1);

    host_state_t        r_state;
    host_state_t        w_next;
    logic [23:0]        r_a1;
    logic [23:0]        r_a2;
    logic [c_CNT_W-1:0] r_poll_cnt;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic               w_req;
    logic               w_we;
    logic [15:0]        w_addr;
    logic [31:0]        w_wdata;
    logic               w_ack;
    logic [31:0]        w_rdata;
    logic               w_status_done;
    logic               w_poll_last;

    gpioemu_bus_xact u_xact (
        .clk       (clk),
        .n_reset   (n_reset),
        .req       (w_req),
        .we        (w_we),
        .addr      (w_addr),
        .wdata     (w_wdata),
        .ack       (w_ack),
        .rdata     (w_rdata),
        .saddress  (saddress),
        .swr       (swr),
        .srd       (srd),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata)
    );

    assign w_status_done = (w_rdata[1:0] == STATUS_DONE);
    assign w_poll_last   = (r_poll_cnt == c_CNT_W'(POLL_LIMIT - 1));
    assign cmd_ready     = (r_state == ST_IDLE);
    assign busy          = (r_state != ST_IDLE);
    assign rsp_valid     = (r_state == ST_RESP);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_req   = 1'b0;
        w_we    = 1'b0;
        w_addr  = 16'h0000;
        w_wdata = 32'h0000_0000;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) w_next = ST_WR_A1;
            end
            ST_WR_A1: begin
                w_req   = 1'b1;
                w_we    = 1'b1;
                w_addr  = ADDR_A1;
                w_wdata = {8'h00, r_a1};
                if (w_ack) w_next = ST_WR_A2;
            end
            ST_WR_A2: begin
                w_req   = 1'b1;
                w_we    = 1'b1;
                w_addr  = ADDR_A2;
                w_wdata = {8'h00, r_a2};
                if (w_ack) w_next = ST_WR_START;
            end
            ST_WR_START: begin
                w_req  = 1'b1;
                w_we   = 1'b1;
                w_addr = ADDR_CTRL;
                if (w_ack) w_next = ST_POLL;
            end
            ST_POLL: begin
                w_req  = 1'b1;
                w_addr = ADDR_CTRL;
                if (w_ack) begin
                    if (w_status_done)      w_next = ST_RD_RES;
                    else if (w_poll_last)   w_next = ST_RESP;
                    else if (POLL_GAP == 0) w_next = ST_POLL;
                    else                    w_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == c_GAP_W'(POLL_GAP - 1)) w_next = ST_POLL;
            end
            ST_RD_RES: begin
                w_req  = 1'b1;
                w_addr = ADDR_RESULT;
                if (w_ack) w_next = ST_RD_ONES;
            end
            ST_RD_ONES: begin
                w_req  = 1'b1;
                w_addr = ADDR_ONES;
                if (w_ack) w_next = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand latch, poll/gap counters and the response registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_a1         <= '0;
            r_a2         <= '0;
            r_poll_cnt   <= '0;
            r_gap_cnt    <= '0;
            rsp_result   <= '0;
            rsp_ones     <= '0;
            rsp_err      <= 1'b0;
`ifdef GPIOEMU_HOST_CHECK_EN
            rsp_mismatch <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_a1       <= cmd_a1;
                        r_a2       <= cmd_a2;
                        r_poll_cnt <= '0;
`ifdef GPIOEMU_HOST_CHECK_EN
                        rsp_mismatch <= 1'b0;
`endif
                    end
                end
                ST_POLL: begin
                    if (w_ack) begin
                        r_poll_cnt <= r_poll_cnt + c_CNT_W'(1);
                        r_gap_cnt  <= '0;
                        if (!w_status_done && w_poll_last) begin
                            rsp_err    <= 1'b1;
                            rsp_result <= '0;
                            rsp_ones   <= '0;
`ifdef GPIOEMU_HOST_CHECK_EN
                            rsp_mismatch <= 1'b0;
`endif
                        end
                    end
                end
                ST_GAP: begin
                    r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
                end
                ST_RD_RES: begin
                    if (w_ack) rsp_result <= w_rdata;
                end
                ST_RD_ONES: begin
                    if (w_ack) begin
                        rsp_ones <= w_rdata[23:0];
                        rsp_err  <= 1'b0;
`ifdef GPIOEMU_HOST_CHECK_EN
                        rsp_mismatch <= ({18'h0, popcount32(rsp_result)} != w_rdata[23:0]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gpioemu_host_master.sv
// ============================================================================
// Module      : tb_gpioemu_host_master
// Description : Self-checking bench with a behavioural gpioemu slave and a
//               transaction-level expectation of each command.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpioemu_host_master;

    localparam int POLL_GAP   = 2;
    localparam int POLL_LIMIT = 4;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [23:0] cmd_a1 = '0;
    logic [23:0] cmd_a2 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic [23:0] rsp_ones;
    logic        rsp_err;
    logic [15:0] saddress;
    logic        swr;
    logic        srd;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        busy;
`ifdef GPIOEMU_HOST_CHECK_EN
    logic        rsp_mismatch;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    gpioemu_host_master #(.POLL_GAP(POLL_GAP), .POLL_LIMIT(POLL_LIMIT)) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a1     (cmd_a1),
        .cmd_a2     (cmd_a2),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_ones   (rsp_ones),
        .rsp_err    (rsp_err),
        .saddress   (saddress),
        .swr        (swr),
        .srd        (srd),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
`ifdef GPIOEMU_HOST_CHECK_EN
        .rsp_mismatch (rsp_mismatch),
`endif
        .busy       (busy)
    );

    function automatic int popc(input logic [47:0] v);
        int n = 0;
        for (int i = 0; i < 48; i++) n += int'(v[i]);
        return n;
    endfunction

    // Behavioural slave: multiplies the written operands, reports "busy"
    // (2'b01) for done_after polls, then "done" (2'b11).
    logic [23:0] slv_a1 = '0;
    logic [23:0] slv_a2 = '0;
    int          slv_polls = 0;
    int          done_after = 0;
    logic [31:0] junk = '0;
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_result = '0;
    logic [23:0] ovr_ones = '0;
    logic [47:0] slv_prod;

    assign slv_prod = {24'h0, slv_a1} * {24'h0, slv_a2};

    always @(negedge clk) begin
        junk <= $urandom;
        if (swr) begin
            if (saddress == 16'h037F) slv_a1 <= bus_wdata[23:0];
            if (saddress == 16'h0388) slv_a2 <= bus_wdata[23:0];
            if (saddress == 16'h03A0) slv_polls <= 0;
        end
        if (srd && saddress == 16'h03A0) slv_polls <= slv_polls + 1;
    end

    always_comb begin
        bus_rdata = junk;
        case (saddress)
            16'h03A0: bus_rdata = {junk[31:2], (slv_polls > done_after) ? 2'b11 : 2'b01};
            16'h0390: bus_rdata = ovr_en ? ovr_result : slv_prod[31:0];
            16'h0398: bus_rdata = {junk[31:24], ovr_en ? ovr_ones : 24'(popc(slv_prod))};
            default:  bus_rdata = junk;
        endcase
    end

    // Bus monitor: transaction log plus strobe-shape violations.
    typedef struct packed {
        logic [15:0] addr;
        logic        we;
        logic [31:0] data;
    } xact_t;

    xact_t       log_q[$];
    int          strobe_viol = 0;
    logic        prev_swr = 1'b0;
    logic        prev_srd = 1'b0;
    logic [15:0] prev_addr = '0;

    always @(negedge clk) begin
        if (swr || srd) log_q.push_back({saddress, swr, swr ? bus_wdata : 32'h0});
        if ((swr && srd) || (swr && prev_swr) || (srd && prev_srd) ||
            ((swr || srd) && saddress != prev_addr))
            strobe_viol <= strobe_viol + 1;
        prev_swr  <= swr;
        prev_srd  <= srd;
        prev_addr <= saddress;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [23:0] a1, input logic [23:0] a2, input int da,
                           input int hold, input bit pre_ready);
        logic [47:0] p;
        bit          ok;
        int          npoll, exp_cycle, n, base, viol0;
        logic [31:0] exp_res;
        logic [23:0] exp_ones;
        bit          stable;
        xact_t       exp_q[$];

        done_after = da;
        p          = {24'h0, a1} * {24'h0, a2};
        ok         = (da + 1 <= POLL_LIMIT);
        npoll      = ok ? da + 1 : POLL_LIMIT;
        exp_res    = ok ? (ovr_en ? ovr_result : p[31:0]) : 32'h0;
        exp_ones   = ok ? (ovr_en ? ovr_ones : 24'(popc(p))) : 24'h0;
        exp_cycle  = 10 + 3 * npoll + POLL_GAP * (npoll - 1) + (ok ? 6 : 0);

        exp_q.push_back({16'h037F, 1'b1, 8'h00, a1});
        exp_q.push_back({16'h0388, 1'b1, 8'h00, a2});
        exp_q.push_back({16'h03A0, 1'b1, 32'h0});
        for (int i = 0; i < npoll; i++) exp_q.push_back({16'h03A0, 1'b0, 32'h0});
        if (ok) begin
            exp_q.push_back({16'h0390, 1'b0, 32'h0});
            exp_q.push_back({16'h0398, 1'b0, 32'h0});
        end

        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1);
        base      = log_q.size();
        viol0     = strobe_viol;
        cmd_valid = 1'b1;
        cmd_a1    = a1;
        cmd_a2    = a2;
        rsp_ready = pre_ready;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_a1    = 24'($urandom);
        cmd_a2    = 24'($urandom);
        check("busy_after_accept", {busy, cmd_ready}, 2'b10);
        while (!rsp_valid && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("rsp_latency", n, exp_cycle);
        check("rsp_result", rsp_result, exp_res);
        check("rsp_ones", rsp_ones, exp_ones);
        check("rsp_err", rsp_err, !ok);
`ifdef GPIOEMU_HOST_CHECK_EN
        check("rsp_mismatch", rsp_mismatch, ok && (popc({16'h0, exp_res}) != int'(exp_ones)));
`endif
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            cmd_valid = i[0];
            @(posedge clk);
            @(negedge clk);
            if (!(rsp_valid && !cmd_ready && rsp_result == exp_res &&
                  rsp_ones == exp_ones && rsp_err == !ok)) stable = 1'b0;
        end
        if (hold > 0) check("rsp_hold_stable", stable, 1);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_handshake", {rsp_valid, cmd_ready, busy}, 3'b010);
        check("xact_count", log_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < log_q.size()) check("xact", log_q[base + i], exp_q[i]);
        end
        check("strobe_shape", strobe_viol - viol0, 0);
    endtask

    initial begin
        int n, base, seen_valid;

        repeat (2) @(negedge clk);
        check("reset_bus", {saddress, swr, srd, bus_wdata}, 50'h0);
        check("reset_rsp", {rsp_valid, rsp_result, rsp_ones, rsp_err, busy}, 59'h0);
`ifdef GPIOEMU_HOST_CHECK_EN
        check("reset_mismatch", rsp_mismatch, 0);
`endif
        n_reset = 1'b1;
        @(negedge clk);
        check("cmd_ready_after_reset", cmd_ready, 1);

        // Two busy polls then done; A1=3, A2=5 -> 15 with 4 ones.
        run_cmd(24'd3, 24'd5, 2, 0, 1'b0);
        // Done on first poll, rsp_ready high in advance.
        run_cmd(24'($urandom), 24'($urandom), 0, 0, 1'b1);
        // Status never completes.
        run_cmd(24'd7, 24'd9, 1000, 0, 1'b0);
        // Response back-pressured for 10 cycles with cmd_valid pulses.
        run_cmd(24'($urandom), 24'($urandom), 1, 10, 1'b0);

        // Reset during the strobe cycle of a status poll.
        done_after = 1000;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_a1    = 24'h123456;
        cmd_a2    = 24'h000042;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!(srd && saddress == 16'h03A0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reached_poll_strobe", srd, 1);
        #1 n_reset = 1'b0;
        #1 check("reset_drops_bus", {srd, swr, saddress}, 18'h0);
        check("reset_no_rsp", rsp_valid, 0);
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        check("cmd_ready_after_midreset", cmd_ready, 1);
        base       = log_q.size();
        seen_valid = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid) seen_valid++;
        end
        check("no_partial_rsp", seen_valid, 0);
        check("bus_quiet_after_reset", log_q.size() - base, 0);
        run_cmd(24'h00ABCD, 24'h000321, 1, 0, 1'b0);

        // Overridden read-back values for the popcount cross-check.
        ovr_en     = 1'b1;
        ovr_result = 32'hFE00_0001;
        ovr_ones   = 24'd7;
        run_cmd(24'd11, 24'd13, 0, 0, 1'b0);
        ovr_ones   = 24'd8;
        run_cmd(24'd11, 24'd13, 0, 0, 1'b0);
        ovr_en     = 1'b0;

        for (int k = 0; k < 8; k++) begin
            int da, hold;
            bit pre;
            da   = int'($urandom_range(0, 5));
            hold = int'($urandom_range(0, 3));
            pre  = (hold == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            run_cmd(24'($urandom), 24'($urandom), da, hold, pre);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
